// File: rtl/ahb_bus_mux.sv
// AHB-Lite address decoder and response multiplexer for one master and NSLAVES slaves.
// Unmapped regions are answered by a built-in default slave with a two-cycle ERROR.
module ahb_bus_mux #(
  parameter int NSLAVES = 3,
  localparam int DSW = $clog2(NSLAVES + 1)
) (
  input  logic                  HMASTCLOCK,
  input  logic                  HRESET,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  output logic [NSLAVES-1:0]    HSEL_S,
  input  logic [32*NSLAVES-1:0] HRDATA_S,
  input  logic [NSLAVES-1:0]    HREADYOUT_S,
  input  logic [NSLAVES-1:0]    HRESP_S,
  output logic                  HREADY,
  output logic [31:0]           HRDATA,
  output logic                  HRESP
);

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  ds_state_t          ds_state, ds_next;
  logic [3:0]         region;
  logic               mapped;
  logic [NSLAVES-1:0] hsel_dec;
  logic [DSW-1:0]     dsel_dec;
  logic [DSW-1:0]     dsel;
  logic               ds_ready;
  logic               ds_resp;
  logic               err_start;

  assign region = HADDR[31:28];
  assign mapped = (region != 4'd0) && (32'(region) <= NSLAVES);

  always_comb begin
    hsel_dec = '0;
    dsel_dec = '0;
    if (mapped) begin
      hsel_dec = NSLAVES'(1) << (region - 4'd1);
      dsel_dec = DSW'(region);
    end
  end

  assign HSEL_S    = HRESET ? '0 : hsel_dec;
  assign err_start = HREADY && !mapped && HTRANS[1];

  always_ff @(posedge HMASTCLOCK) begin
    if (HRESET) begin
      dsel     <= '0;
      ds_state <= DS_IDLE;
    end else begin
      if (HREADY)
        dsel <= dsel_dec;
      ds_state <= ds_next;
    end
  end

  always_comb begin
    ds_next  = ds_state;
    ds_ready = 1'b1;
    ds_resp  = 1'b0;
    unique case (ds_state)
      DS_IDLE: begin
        if (err_start)
          ds_next = DS_ERR1;
      end
      DS_ERR1: begin
        ds_ready = 1'b0;
        ds_resp  = 1'b1;
        ds_next  = DS_ERR2;
      end
      DS_ERR2: begin
        ds_resp = 1'b1;
        ds_next = err_start ? DS_ERR1 : DS_IDLE;
      end
      default: ds_next = DS_IDLE;
    endcase
  end

  // dsel only ever holds 0 or a mapped slave number, so the default path covers dsel = 0.
  always_comb begin
    HRDATA = '0;
    HREADY = ds_ready;
    HRESP  = ds_resp;
    for (int unsigned k = 1; k <= NSLAVES; k++) begin
      if (32'(dsel) == k) begin
        HRDATA = HRDATA_S[32*(k-1) +: 32];
        HREADY = HREADYOUT_S[k-1];
        HRESP  = HRESP_S[k-1];
      end
    end
  end

endmodule

// File: tb/tb_ahb_bus_mux.sv
// Directed bench for ahb_bus_mux: decode, data-phase mux, wait states, default-slave errors, reset.
module tb_ahb_bus_mux;

  localparam int NS = 3;

  logic            HMASTCLOCK = 1'b0;
  logic            HRESET;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic [NS-1:0]   HSEL_S;
  logic [32*NS-1:0] HRDATA_S;
  logic [NS-1:0]   HREADYOUT_S;
  logic [NS-1:0]   HRESP_S;
  logic            HREADY;
  logic [31:0]     HRDATA;
  logic            HRESP;

  int errors = 0;
  int checks = 0;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;

  ahb_bus_mux #(.NSLAVES(NS)) dut (
    .HMASTCLOCK (HMASTCLOCK),
    .HRESET     (HRESET),
    .HADDR      (HADDR),
    .HTRANS     (HTRANS),
    .HSEL_S     (HSEL_S),
    .HRDATA_S   (HRDATA_S),
    .HREADYOUT_S(HREADYOUT_S),
    .HRESP_S    (HRESP_S),
    .HREADY     (HREADY),
    .HRDATA     (HRDATA),
    .HRESP      (HRESP)
  );

  always #5 HMASTCLOCK = ~HMASTCLOCK;

  // Slave k returns a fixed word k<<28.
  assign HRDATA_S = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge HMASTCLOCK);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [1:0] t);
    HADDR  = a;
    HTRANS = t;
    #1;
  endtask

  task automatic check_out(input string tag, input logic rdy, input logic rsp, input logic [31:0] d);
    check({tag, "_hready"}, 32'(HREADY), 32'(rdy));
    check({tag, "_hresp"},  32'(HRESP),  32'(rsp));
    check({tag, "_hrdata"}, HRDATA, d);
  endtask

  initial begin
    HRESET      = 1'b1;
    HREADYOUT_S = '1;
    HRESP_S     = '0;
    drive(32'h2000_0000, NONSEQ);
    check("rst_hsel0", 32'(HSEL_S), 32'h0);
    tick();
    check("rst_hsel1", 32'(HSEL_S), 32'h0);
    tick();
    HRESET = 1'b0;
    drive(32'h0000_0000, IDLE);
    check_out("after_rst", 1'b1, 1'b0, 32'h0);

    // mapped read to slave 2
    drive(32'h2000_0010, NONSEQ);
    check("map_hsel", 32'(HSEL_S), 32'h2);
    tick();
    drive(32'h0000_0000, IDLE);
    check_out("map_dp", 1'b1, 1'b0, 32'h2000_0000);

    // unmapped active transfer
    drive(32'h0000_0004, NONSEQ);
    check("unm_hsel", 32'(HSEL_S), 32'h0);
    tick();
    drive(32'h0000_0000, IDLE);
    check_out("unm_err1", 1'b0, 1'b1, 32'h0);
    tick();
    check_out("unm_err2", 1'b1, 1'b1, 32'h0);
    tick();
    check_out("unm_done", 1'b1, 1'b0, 32'h0);

    // unmapped idle: zero-wait OKAY
    drive(32'hF000_0000, IDLE);
    check("idle_hsel", 32'(HSEL_S), 32'h0);
    tick();
    check_out("idle_dp", 1'b1, 1'b0, 32'h0);
    tick();
    check_out("idle_dp2", 1'b1, 1'b0, 32'h0);

    // wait states from slave 1 with slave 3 address pending
    drive(32'h1000_0000, NONSEQ);
    tick();
    HREADYOUT_S = 3'b110;
    drive(32'h3000_0000, NONSEQ);
    check("ws_hsel", 32'(HSEL_S), 32'h4);
    check_out("ws_c1", 1'b0, 1'b0, 32'h1000_0000);
    tick();
    check_out("ws_c2", 1'b0, 1'b0, 32'h1000_0000);
    tick();
    HREADYOUT_S = 3'b111;
    #1;
    check_out("ws_c3", 1'b1, 1'b0, 32'h1000_0000);
    tick();
    // slave 3 data phase; slave response passed through, next address unmapped
    HRESP_S = 3'b100;
    drive(32'h0000_0000, NONSEQ);
    check_out("ws_s3", 1'b1, 1'b1, 32'h3000_0000);
    HRESP_S = 3'b000;
    #1;
    check("ws_s3_okay", 32'(HRESP), 32'h0);

    // back-to-back unmapped errors, then reset during second ERR1
    tick();
    check_out("b2b_err1a", 1'b0, 1'b1, 32'h0);
    tick();
    check_out("b2b_err2a", 1'b1, 1'b1, 32'h0);
    tick();
    check_out("b2b_err1b", 1'b0, 1'b1, 32'h0);
    HRESET = 1'b1;
    drive(32'h2000_0000, NONSEQ);
    check("b2b_rst_hsel", 32'(HSEL_S), 32'h0);
    tick();
    HRESET = 1'b0;
    drive(32'h0000_0000, IDLE);
    check_out("b2b_rst", 1'b1, 1'b0, 32'h0);
    tick();
    check_out("b2b_rst2", 1'b1, 1'b0, 32'h0);

    // reset during a mapped data phase clears the data-phase select
    drive(32'h2000_0000, NONSEQ);
    tick();
    drive(32'h0000_0000, IDLE);
    check_out("map2_dp", 1'b1, 1'b0, 32'h2000_0000);
    HRESET = 1'b1;
    #1;
    tick();
    HRESET = 1'b0;
    #1;
    check_out("map2_rst", 1'b1, 1'b0, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/ahb_bus_mux.md
# ahb_bus_mux

AHB-Lite interconnect stage between the single bus master and the peripheral slaves. Decodes the address phase into per-slave HSEL lines, registers the selected slave for the data phase, and multiplexes each slave's HRDATA/HREADYOUT/HRESP back to the master. It also holds the HREADY loop closed for all slaves. A built-in default slave answers unmapped regions with a two-cycle AHB ERROR response.

## Interface
- NSLAVES, 3: number of attached slaves (1..15); slave k (1-based) owns region HADDR[31:28] == k.
- DSW, $clog2(NSLAVES+1): width of the data-phase select register (internal, derived).

- HMASTCLOCK  in  1  bus clock; all state updates on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- HADDR  in  32  master address-phase address.
- HTRANS  in  2  master transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ).
- HSEL_S  out  NSLAVES  bit k-1 selects slave k; combinational from HADDR.
- HRDATA_S  in  32*NSLAVES  slave k read data at bits [32k-1:32(k-1)].
- HREADYOUT_S  in  NSLAVES  slave k ready, bit k-1.
- HRESP_S  in  NSLAVES  slave k response, bit k-1 (0 OKAY, 1 ERROR).
- HREADY  out  1  muxed ready to master, fed back to every slave's HREADY.
- HRDATA  out  32  muxed read data to master.
- HRESP  out  1  muxed response to master.

## Operation
- Decode: region = HADDR[31:28]. If 1 ≤ region ≤ NSLAVES, HSEL_S = one-hot bit region-1; otherwise HSEL_S = 0 and the transfer is "unmapped" (default slave). Region 0 is always unmapped. HSEL_S is forced to 0 while HRESET = 1.
- Data-phase select dsel (0 = default slave, k = slave k):
  - Loads the decoded value on a rising edge with HREADY = 1.
  - Holds while HREADY = 0.
  - Reset value 0.
- Default slave FSM, states DS_IDLE, DS_ERR1, DS_ERR2:
  - DS_IDLE: drives ready = 1, resp = 0. On an edge with HREADY = 1, unmapped decode and HTRANS[1] = 1, go to DS_ERR1. Otherwise stay.
  - DS_ERR1: drives ready = 0, resp = 1. Always goes to DS_ERR2.
  - DS_ERR2: drives ready = 1, resp = 1. HREADY = 1 here, so the next address phase is sampled. Unmapped with HTRANS[1] = 1 goes to DS_ERR1; anything else goes to DS_IDLE.
  - Reset state: DS_IDLE.
- IDLE/BUSY transfers to unmapped regions get a zero-wait OKAY response (FSM stays in DS_IDLE).
- IDLE/BUSY to mapped regions still select the slave. The slave's own response is passed through unchanged.
- Output mux (combinational from dsel, FSM and slave inputs):
  - dsel = 0: HRDATA = 32'h0000_0000; HREADY and HRESP come from the default slave.
  - dsel = k: HRDATA = slice k, HREADY = HREADYOUT_S[k-1], HRESP = HRESP_S[k-1].
- Reset mid-transfer: HRESET overrides any wait or error sequence. The in-flight transfer is abandoned, and no partial ERROR is completed.

## Timing
- Output values after reset: HREADY = 1, HRESP = 0, HRDATA = 0, HSEL_S = 0.
- Decode latency: 0 cycles. HSEL_S is valid in the same cycle as HADDR.
- Data-phase latency: 1 cycle. Slave k's outputs appear on HRDATA/HREADY/HRESP in the cycle after its address phase is accepted (edge with HREADY = 1). This matches slaves that register their response on HSEL.
- Wait states: while the selected slave holds HREADYOUT low, dsel and the FSM freeze. The pending address phase may already drive a different HSEL_S bit, but it is not accepted until HREADY = 1.
- Unmapped active transfer: exactly 2 data-phase cycles, (ready 0, ERROR) then (ready 1, ERROR). Back-to-back unmapped transfers give ERR1, ERR2, ERR1, ERR2 with no DS_IDLE cycle between them.
- Reset behaviour: HRESET sampled high forces dsel = 0 and FSM = DS_IDLE at that edge. Outputs show reset values from the following cycle.

## Test plan
- Reset: HRESET = 1 for 2 cycles with HADDR = 0x2000_0000 -> HSEL_S = 3'b000 during reset; afterwards HREADY = 1, HRESP = 0, HRDATA = 0x0000_0000.
- Mapped read: NONSEQ to HADDR = 0x2000_0010 -> HSEL_S = 3'b010 in the same cycle; next cycle HRDATA = 0x2000_0000 (slave 2 data), HREADY = 1, HRESP = 0.
- Unmapped error: NONSEQ to 0x0000_0004 -> next cycle HREADY = 0, HRESP = 1; then HREADY = 1, HRESP = 1; then, with HTRANS = IDLE, HREADY = 1, HRESP = 0.
- Unmapped idle: HTRANS = IDLE to 0xF000_0000 -> next cycle HREADY = 1, HRESP = 0; FSM never leaves DS_IDLE.
- Wait state: slave 1 selected, HREADYOUT_S[0] = 0 for 2 cycles while HADDR = 0x3000_0000 is presented -> HREADY = 0 for both cycles; HSEL_S = 3'b100, but HRDATA stays on slice 1; slave 3 data appears one cycle after HREADYOUT_S[0] returns to 1.
- Back-to-back and reset: two consecutive NONSEQ to 0x0000_0000 -> ERR1, ERR2, ERR1; HRESET asserted during the second ERR1 -> next cycle HREADY = 1, HRESP = 0, HRDATA = 0.
